// File: rtl/modarith_pkg.sv
// Shared definitions for the Fermat-modulus arithmetic pipeline: op codes,
// modulus helper and the per-stage control entry.
package modarith_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Q = 2^(logq-1) + 1; 33 bits covers logq up to 32.
    function automatic logic [32:0] q_of(input int unsigned logq);
        return (33'd1 << (logq - 1)) + 33'd1;
    endfunction

    // Control part of a stage entry; data-width fields (p/t, tag) depend on
    // module parameters and sit beside it in the pipeline.
    typedef struct packed {
        logic valid;
        op_e  op;
        logic err;
    } stage_ctl_t;

endpackage

// File: rtl/fermat_fold.sv
// Combinational fold of a stage value modulo Q = 2^K + 1 into a signed value
// that needs at most one +Q correction.
module fermat_fold
    import modarith_pkg::*;
#(
    parameter int unsigned LOGQ = 17
) (
    input  op_e                 op,
    input  logic [2*LOGQ-1:0]   p,
    output logic [LOGQ:0]       t
);

    localparam int unsigned   K  = LOGQ - 1;
    localparam logic [LOGQ:0] QW = (LOGQ + 1)'(q_of(LOGQ));

    logic [LOGQ:0] lo;
    logic [LOGQ:0] hi;

    // 2^K == -1 mod Q, so a product folds as low K bits minus the rest.
    assign lo = {2'b00, p[K-1:0]};
    assign hi = p[2*LOGQ-1:K];

    always_comb begin
        if (op == OP_MUL) begin
            t = lo - hi;
        end else begin
            t = p[LOGQ:0] - QW;
        end
    end

endmodule

// File: rtl/modarith_pipe.sv
// Three-stage pipelined MUL/ADD/SUB modulo Q = 2^(LOGQ-1) + 1 with a global
// stall, valid/ready handshake and tag passthrough.
module modarith_pipe
    import modarith_pkg::*;
#(
    parameter int unsigned LOGQ = 17,
    parameter int unsigned TAGW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [LOGQ-1:0]  in_a,
    input  logic [LOGQ-1:0]  in_b,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  out_s,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned     PW = 2 * LOGQ;
    localparam logic [PW-1:0]   QP = PW'(q_of(LOGQ));
    localparam logic [LOGQ-1:0] QS = LOGQ'(q_of(LOGQ));

    logic en;
    op_e  op_in;

    // S1: raw product / sum
    logic [PW-1:0]   p_d;
    logic            err_d;
    stage_ctl_t      s1_ctl_q;
    logic [PW-1:0]   s1_p_q;
    logic [TAGW-1:0] s1_tag_q;

    // S2: folded signed value
    logic [LOGQ:0]   t_d;
    logic            s2_valid_q;
    logic            s2_err_q;
    logic [LOGQ:0]   s2_t_q;
    logic [TAGW-1:0] s2_tag_q;

    // S3: corrected result
    logic [LOGQ-1:0] s_d;
    logic            s3_valid_q;
    logic            s3_err_q;
    logic [LOGQ-1:0] s3_s_q;
    logic [TAGW-1:0] s3_tag_q;

    assign en       = !s3_valid_q || out_ready;
    assign in_ready = en;
    assign op_in    = op_e'(in_op);

    always_comb begin
        p_d   = '0;
        err_d = 1'b0;
        case (op_in)
            OP_MUL:  p_d = PW'(in_a) * PW'(in_b);
            OP_ADD:  p_d = PW'(in_a) + PW'(in_b);
            OP_SUB:  p_d = PW'(in_a) + QP - PW'(in_b);
            default: err_d = 1'b1;
        endcase
    end

    fermat_fold #(
        .LOGQ (LOGQ)
    ) u_fold (
        .op (s1_ctl_q.op),
        .p  (s1_p_q),
        .t  (t_d)
    );

    // t lies in [-Q, Q-1]; wrap-around in LOGQ bits yields t + Q for negatives.
    always_comb begin
        if (s2_t_q[LOGQ]) begin
            s_d = s2_t_q[LOGQ-1:0] + QS;
        end else begin
            s_d = s2_t_q[LOGQ-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ctl_q   <= '0;
            s1_p_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_t_q     <= '0;
            s2_tag_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_err_q   <= 1'b0;
            s3_s_q     <= '0;
            s3_tag_q   <= '0;
        end else if (en) begin
            s1_ctl_q   <= '{valid: in_valid, op: op_in, err: err_d};
            s1_p_q     <= p_d;
            s1_tag_q   <= in_tag;
            s2_valid_q <= s1_ctl_q.valid;
            s2_err_q   <= s1_ctl_q.err;
            s2_t_q     <= t_d;
            s2_tag_q   <= s1_tag_q;
            s3_valid_q <= s2_valid_q;
            s3_err_q   <= s2_err_q;
            s3_s_q     <= s_d;
            s3_tag_q   <= s2_tag_q;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_s     = s3_s_q;
    assign out_tag   = s3_tag_q;
    assign out_err   = s3_err_q;
    assign busy      = s1_ctl_q.valid | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_modarith_pipe.sv
// Scoreboard bench for modarith_pipe: driver pushes reference results, an
// independent monitor pops and compares on every output transfer.
module tb_modarith_pipe;

    localparam int unsigned LOGQ = 17;
    localparam int unsigned TAGW = 8;
    localparam longint      Q    = 65537;
    localparam int          LAT  = 3;   // edges, counting the accept edge

    typedef struct {
        logic [LOGQ-1:0] s;
        logic [TAGW-1:0] tag;
        logic            err;
        int              acc;
        bit              chk_lat;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [LOGQ-1:0] in_a;
    logic [LOGQ-1:0] in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_s;
    logic [TAGW-1:0] out_tag;
    logic            out_err;
    logic            busy;

    exp_t sb[$];
    exp_t mon_e;
    int   out_cyc[$];
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    bit   lat_chk = 1'b1;

    modarith_pipe #(
        .LOGQ (LOGQ),
        .TAGW (TAGW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic logic [LOGQ-1:0] ref_s(input logic [1:0] op, input longint a,
                                              input longint b);
        longint r;
        case (op)
            2'b00:   r = (a * b) % Q;
            2'b01:   r = (a + b) % Q;
            2'b10:   r = (a - b + Q) % Q;
            default: r = 0;
        endcase
        return LOGQ'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst && in_valid) begin
            assert (longint'(in_a) < Q && longint'(in_b) < Q)
                else $error("operand out of range driven: a=%0d b=%0d", in_a, in_b);
        end
    end

    // Monitor: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got s=%0d tag=%0h, expected none", out_s, out_tag);
            end else begin
                mon_e = sb.pop_front();
                check("out_s", 64'(out_s), 64'(mon_e.s));
                check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                check("out_err", 64'(out_err), 64'(mon_e.err));
                if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.acc + 1), 64'(LAT));
            end
        end
    end

    // exp_s < 0 takes the reference model's value.
    task automatic send(input logic [1:0] op, input logic [LOGQ-1:0] a,
                        input logic [LOGQ-1:0] b, input logic [TAGW-1:0] tag,
                        input int exp_s);
        exp_t e;
        bit   ok = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0d, expected 1 within 200 cycles", in_ready);
        end else begin
            e.s       = (exp_s >= 0) ? LOGQ'(exp_s) : ref_s(op, a, b);
            e.tag     = tag;
            e.err     = (op == 2'b11);
            e.acc     = cyc + 1;
            e.chk_lat = lat_chk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic stall_ctl();
        bit              ok = 1'b0;
        logic [LOGQ-1:0] hs;
        logic [TAGW-1:0] ht;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_out_valid", 64'(ok), 64'd1);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        hs = out_s;
        ht = out_tag;
        repeat (5) begin
            @(negedge clk);
            check("hold_s", 64'(out_s), 64'(hs));
            check("hold_tag", 64'(out_tag), 64'(ht));
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // Three held entries plus the waiting op must stream out without a gap.
        repeat (4) begin
            @(negedge clk);
            check("release_valid", 64'(out_valid), 64'd1);
        end
    endtask

    logic [1:0]  d_op  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    int          d_a   [8] = '{65536, 256, 0, 3, 65536, 40000, 0, 7};
    int          d_b   [8] = '{65536, 256, 12345, 5, 1, 30000, 1, 7};
    int          d_exp [8] = '{1, 65536, 0, 15, 0, 4463, 65536, 0};

    function automatic logic [LOGQ-1:0] rand_operand();
        int unsigned pick;
        logic [LOGQ-1:0] edges [4] = '{17'd0, 17'd1, 17'd65535, 17'd65536};
        pick = $urandom_range(0, 3);
        if (pick == 0) return edges[$urandom_range(0, 3)];
        return LOGQ'($urandom_range(0, 65536));
    endfunction

    initial begin
        int          n0;
        int unsigned r;
        logic [1:0]  op;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_s", 64'(out_s), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed values on an idle pipe.
        for (int i = 0; i < 8; i++) begin
            send(d_op[i], LOGQ'(d_a[i]), LOGQ'(d_b[i]), TAGW'(i + 1), d_exp[i]);
            drain("directed_drain");
        end

        // Reserved op, then a normal op behind it.
        send(2'b11, 17'd123, 17'd456, 8'h5A, 0);
        send(2'b00, 17'd2, 17'd3, 8'h5B, 6);
        drain("reserved_drain");

        // Back-to-back random stream.
        n0 = out_cyc.size();
        for (int i = 0; i < 100; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            send(op, rand_operand(), rand_operand(), TAGW'($urandom), -1);
        end
        drain("stream_drain");
        check("stream_count", 64'(out_cyc.size() - n0), 64'd100);
        if (out_cyc.size() - n0 == 100) begin
            check("stream_no_bubbles", 64'(out_cyc[n0 + 99] - out_cyc[n0]), 64'd99);
        end

        // Backpressure: four ops against a stalled consumer.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(2'(i % 3), rand_operand(), rand_operand(), TAGW'(8'hC0 + i), -1);
                end
            end
            stall_ctl();
        join
        drain("stall_drain");
        lat_chk = 1'b1;

        // Asynchronous reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            send(2'b01, rand_operand(), rand_operand(), TAGW'(8'hE0 + i), -1);
        end
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(2'b00, 17'd65536, 17'd2, 8'h77, -1);
        drain("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
